// File: rtl/stop_watch_pkg.sv
// Shared constants for the stopwatch: digit limits, widths and the
// active-low gfedcba seven-segment codes.
package stop_watch_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned TENTHS_W = 10;

  localparam logic [DIGIT_W-1:0] TENS_MAX  = 4'd5;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment code; non-decimal values blank the digit.
module seg7_decoder
  import stop_watch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stop_watch.sv
// Start/stop stopwatch counting 00.0 to 59.9 s in tenths, driven by one
// debounced-by-synchronizer pushbutton; display decode is combinational.
module stop_watch
  import stop_watch_pkg::*;
#(
  parameter int unsigned TICKS_PER_TENTH = 5000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STRTSTOP,
  output logic [6:0]  ONESOUT,
  output logic [6:0]  TENSOUT,
  output logic [9:0]  TENTHSOUT
);

  localparam int unsigned PRESC_W = (TICKS_PER_TENTH > 2) ? $clog2(TICKS_PER_TENTH) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_TENTH - 1);

  logic               sync1_q, sync2_q, sync3_q;
  logic               run_q, run_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DIGIT_W-1:0] tenths_q, tenths_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic               press;
  logic               tick;

  // sync3_q holds the previous synchronized level for falling-edge detection
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      sync3_q  <= 1'b1;
      run_q    <= 1'b0;
      presc_q  <= '0;
      tenths_q <= '0;
      ones_q   <= '0;
      tens_q   <= '0;
    end else begin
      sync1_q  <= STRTSTOP;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      run_q    <= run_d;
      presc_q  <= presc_d;
      tenths_q <= tenths_d;
      ones_q   <= ones_d;
      tens_q   <= tens_d;
    end
  end

  // A tick coinciding with a stopping press still lands before run drops.
  always_comb begin
    press    = sync3_q & ~sync2_q;
    tick     = run_q && (presc_q == PRESC_LAST);
    run_d    = run_q;
    presc_d  = presc_q;
    tenths_d = tenths_q;
    ones_d   = ones_q;
    tens_d   = tens_q;

    if (run_q) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    if (tick) begin
      if (tenths_q == DIGIT_MAX) begin
        tenths_d = '0;
        if (ones_q == DIGIT_MAX) begin
          ones_d = '0;
          tens_d = (tens_q == TENS_MAX) ? '0 : tens_q + DIGIT_W'(1);
        end else begin
          ones_d = ones_q + DIGIT_W'(1);
        end
      end else begin
        tenths_d = tenths_q + DIGIT_W'(1);
      end
    end

    if (press) begin
      run_d = ~run_q;
    end
  end

  seg7_decoder u_ones_dec (
    .bcd_i (ones_q),
    .seg_o (ONESOUT)
  );

  seg7_decoder u_tens_dec (
    .bcd_i (tens_q),
    .seg_o (TENSOUT)
  );

  // Out-of-range tenths shift past bit 9 and leave the indicator dark
  assign TENTHSOUT = TENTHS_W'(1) << tenths_q;

endmodule

// File: tb/tb_stop_watch.sv
// Directed bench for stop_watch with TICKS_PER_TENTH=4: reset, start latency,
// carries, 59.9 rollover, stop/resume, press+tick coincidence, async reset.
module tb_stop_watch;

  logic       clk;
  logic       rst_n;
  logic       strt;
  logic [6:0] ones_out;
  logic [6:0] tens_out;
  logic [9:0] tenths_out;

  int checks;
  int failures;

  stop_watch #(.TICKS_PER_TENTH(4)) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .STRTSTOP  (strt),
    .ONESOUT   (ones_out),
    .TENSOUT   (tens_out),
    .TENTHSOUT (tenths_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_exp(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk_time(input string tag, input int tens, input int ones, input int tenths);
    logic [9:0] hot;
    hot = 10'b1 << tenths;
    check_eq({tag, "_tens"},   32'(tens_out),   32'(seg_exp(tens)));
    check_eq({tag, "_ones"},   32'(ones_out),   32'(seg_exp(ones)));
    check_eq({tag, "_tenths"}, 32'(tenths_out), 32'(hot));
  endtask

  // Each step lands on a falling edge, exactly one rising edge later
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    strt     = 1'b1;

    #1 rst_n = 1'b0;
    #1 chk_time("rst_async", 0, 0, 0);
    step(3);
    chk_time("rst_held", 0, 0, 0);
    rst_n = 1'b1;
    step(5);
    chk_time("idle", 0, 0, 0);

    // Start: run sets on the 3rd edge, first tick 4 edges after that
    strt = 1'b0;
    step(6);
    chk_time("pre_tick", 0, 0, 0);
    step(1);
    chk_time("tick1", 0, 0, 1);
    step(32);
    chk_time("tick9", 0, 0, 9);
    step(4);
    chk_time("tick10", 0, 1, 0);
    step(360);
    chk_time("tick100", 1, 0, 0);
    step(1996);
    chk_time("tick599", 5, 9, 9);
    step(4);
    chk_time("wrap600", 0, 0, 0);
    step(4);
    chk_time("tick601", 0, 0, 1);

    // Stop two prescaler cycles past 0.3
    strt = 1'b1;
    step(7);
    strt = 1'b0;
    step(1);
    chk_time("tick603", 0, 0, 3);
    step(22);
    chk_time("frozen", 0, 0, 3);

    // Resume from the held prescaler value of 2
    strt = 1'b1;
    step(4);
    strt = 1'b0;
    step(4);
    chk_time("resume_wait", 0, 0, 3);
    step(1);
    chk_time("resume_tick", 0, 0, 4);

    // Press pulse lands on the same edge as a tick
    strt = 1'b1;
    step(5);
    strt = 1'b0;
    step(2);
    chk_time("pre_coincide", 0, 0, 5);
    step(1);
    chk_time("coincide", 0, 0, 6);
    step(12);
    chk_time("coincide_stop", 0, 0, 6);

    // Run on to 12.7 s
    strt = 1'b1;
    step(4);
    strt = 1'b0;
    step(6);
    chk_time("restart_wait", 0, 0, 6);
    step(1);
    chk_time("restart_tick", 0, 0, 7);
    step(480);
    chk_time("at_12_7", 1, 2, 7);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1 chk_time("rst_mid", 0, 0, 0);
    strt = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(20);
    chk_time("post_rst_stopped", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
